vending_fsm_n: RTL and testbench
================================

# vending_fsm_n

Parametrised multi-product vending controller. Accumulates coin credit, sells one of `N_PROD` products at per-product prices, and refunds the remainder as a stream of unit change pulses. Supports cancel/refund, sold-out masking, and overflow-safe credit. Sits between the coin acceptor decoder and the product dispenser/change hopper drivers.

## Interface
Parameters:
- `N_PROD`, 4: number of products.
- `CREDIT_W`, 6: credit width; maximum credit is 2^CREDIT_W-1.
- `PRICES`, {6'd5,6'd4,6'd3,6'd2}: packed `N_PROD*CREDIT_W`. Price of product i is `PRICES[i*CREDIT_W +: CREDIT_W]`. Every price must be ≥1.
- `COIN_VALS`, {6'd4,6'd3,6'd2}: packed `3*CREDIT_W`. The value for coin code k (1..3) is slice k-1. Code 0 means no coin.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `moneda` in 2: coin code, sampled every cycle.
- `comprar` in N_PROD: purchase request; only the lowest set bit is considered.
- `cancel` in 1: refund request.
- `sold_out` in N_PROD: product unavailable.
- `total` out CREDIT_W: current credit (registered).
- `listo` out N_PROD: combinational; `listo[i]` = (state==CREDIT) & (total ≥ price_i) & ~sold_out[i].
- `vend` out N_PROD: registered one-hot, one-cycle dispense pulse.
- `change_pulse` out 1: combinational, equals (state==CHANGE). Each high cycle returns one credit unit.
- `busy` out 1: equals (state==CHANGE).
- `coin_reject` out 1: registered one-cycle pulse.

## Operation
States:
- IDLE: credit is 0.
- CREDIT: credit > 0, accepting purchases.
- CHANGE: refunding the remainder.

Transitions on each edge, applied in priority order within a cycle:
1. `reset`: go to IDLE; `total`=0, `vend`=0, `coin_reject`=0. Hence `listo`=0, `change_pulse`=0, `busy`=0. Reset mid-CHANGE discards the remaining credit and emits no further pulses.
2. CHANGE:
   - `total` decrements by 1.
   - When `total`==1, go to IDLE.
   - `comprar` and `cancel` are ignored.
   - Any nonzero `moneda` is rejected.
3. CREDIT with `cancel`=1: go to CHANGE; `total` is unchanged. The cancel wins over `comprar`. A coin in the same cycle is rejected.
4. CREDIT with a purchase accepted:
   - Acceptance condition: i = lowest set bit of `comprar`, and `listo[i]`=1.
   - Actions: `vend` <= onehot(i); `total` <= total - price_i.
   - Next state: CHANGE if the result is >0, else IDLE.
   - A coin in the same cycle is rejected.
   - If bit i is not eligible, there is no vend and no fallthrough to a higher bit.
5. IDLE/CREDIT with a coin (`moneda`≠0):
   - If total + value > 2^CREDIT_W-1: `coin_reject` pulses and `total` is unchanged.
   - Otherwise `total` += value and the state goes to CREDIT.
6. `cancel` in IDLE is a no-op.

Arithmetic:
- Sums are computed at CREDIT_W+1 bits for the overflow check.
- Subtraction cannot underflow because acceptance guarantees total ≥ price.
- The number of `change_pulse` cycles equals the credit held on entry to CHANGE.

## Timing
- Coin sampled at edge t: `total` updated in cycle t+1. `coin_reject`, if any, is high for cycle t+1 only.
- Purchase accepted at edge t: `vend` is high for cycle t+1 only. `total` shows the remainder in t+1. CHANGE pulses occupy cycles t+1 .. t+remainder.
- Cancel at edge t with credit C: `change_pulse` is high for cycles t+1 .. t+C, and the state is IDLE at t+C+1.
- `listo` follows `total`/state/`sold_out` combinationally, with no added latency.
- Back-to-back: a new coin is accepted on the first edge the state is IDLE.

## Test plan
1. Reset, then `moneda`=1, then `moneda`=2 → `total`=2, then 5; `listo`=4'b1111; `vend`=0.
2. Credit 5, `comprar`=4'b0010 → `vend`=4'b0010 for 1 cycle, `total`=2, then 2 `change_pulse` cycles, then IDLE with `total`=0.
3. Credit 4, `comprar`=4'b1100 with `moneda`=1 in the same cycle → `vend`=4'b0100, `coin_reject` pulse, `total`=0, IDLE, zero change pulses.
4. Fifteen `moneda`=3 coins (`total`=60), then one more `moneda`=3 → `coin_reject` pulse, `total` stays 60. Then `cancel` → exactly 60 `change_pulse` cycles, with `busy` high throughout.
5. Credit 5, `sold_out`=4'b1000, `comprar`=4'b1000 → `listo[3]`=0, no vend, `total`=5, still CREDIT. Then `comprar`=4'b1001 → `vend`=4'b0001.
6. Credit 7, `cancel`, assert `reset` after 3 pulses → next cycle `total`=0, `change_pulse`=0, IDLE. A coin during CHANGE → `coin_reject`.

Source files
------------

// File: rtl/vending_fsm_n_if.sv
// -----------------------------------------------------------------------------
// vending_fsm_n_if
//
// Bundles the coin/purchase/dispense signals of the vending controller.
//
// Signals:
//   moneda       [1:0]        coin code from the acceptor decoder (0 = no coin)
//   comprar      [N_PROD-1:0] purchase request, lowest set bit wins
//   cancel                    refund request
//   sold_out     [N_PROD-1:0] product unavailable
//   total        [CREDIT_W-1:0] current credit (registered)
//   listo        [N_PROD-1:0] product purchasable now (combinational)
//   vend         [N_PROD-1:0] one-cycle one-hot dispense pulse (registered)
//   change_pulse              one credit unit returned this cycle
//   busy                      controller is paying out change
//   coin_reject               one-cycle coin rejection pulse (registered)
//
// Modports:
//   master : the environment (coin decoder, keypad, stock sensors)
//   slave  : the vending controller
// -----------------------------------------------------------------------------
interface vending_fsm_n_if #(
    parameter int N_PROD   = 4,
    parameter int CREDIT_W = 6
);
    logic [1:0]          moneda;
    logic [N_PROD-1:0]   comprar;
    logic                cancel;
    logic [N_PROD-1:0]   sold_out;
    logic [CREDIT_W-1:0] total;
    logic [N_PROD-1:0]   listo;
    logic [N_PROD-1:0]   vend;
    logic                change_pulse;
    logic                busy;
    logic                coin_reject;

    modport master (
        output moneda, comprar, cancel, sold_out,
        input  total, listo, vend, change_pulse, busy, coin_reject
    );

    modport slave (
        input  moneda, comprar, cancel, sold_out,
        output total, listo, vend, change_pulse, busy, coin_reject
    );
endinterface

// File: rtl/vending_fsm_n.sv
// -----------------------------------------------------------------------------
// vending_fsm_n
//
// Multi-product vending controller. Accumulates coin credit, sells one of
// N_PROD products at per-product prices and pays back the remainder as a
// stream of unit change pulses. Supports cancel/refund, sold-out masking and
// overflow-safe credit accumulation.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : vending_fsm_n_if.slave
//              in : moneda, comprar, cancel, sold_out
//              out: total, listo, vend, change_pulse, busy, coin_reject
//
// Parameters:
//   N_PROD    : number of products
//   CREDIT_W  : credit width, maximum credit 2^CREDIT_W-1
//   PRICES    : packed prices, product i at [i*CREDIT_W +: CREDIT_W] (all >= 1)
//   COIN_VALS : packed coin values, code k (1..3) at slice k-1
// -----------------------------------------------------------------------------
module vending_fsm_n #(
    parameter int                         N_PROD    = 4,
    parameter int                         CREDIT_W  = 6,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICES    = {6'd5, 6'd4, 6'd3, 6'd2},
    parameter logic [3*CREDIT_W-1:0]      COIN_VALS = {6'd4, 6'd3, 6'd2}
) (
    input  logic            clk,
    input  logic            reset,
    vending_fsm_n_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        CHANGE = 2'd2
    } state_t;

    state_t              state;
    logic [CREDIT_W-1:0] credit;
    logic [N_PROD-1:0]   vend_pulse;
    logic                reject_pulse;

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------
    function automatic logic [CREDIT_W-1:0] price_of(input int unsigned idx);
        return PRICES[idx*CREDIT_W +: CREDIT_W];
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
        logic [CREDIT_W-1:0] val;
        val = '0;
        if (code != 2'd0)
            val = COIN_VALS[(int'(code) - 1)*CREDIT_W +: CREDIT_W];
        return val;
    endfunction

    // One extra bit so that overflow past 2^CREDIT_W-1 is visible in the MSB.
    function automatic logic [CREDIT_W:0] add_wide(input logic [CREDIT_W-1:0] a,
                                                   input logic [CREDIT_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [N_PROD-1:0]   listo_comb;
    logic [N_PROD-1:0]   sel_onehot;
    logic [CREDIT_W-1:0] sel_price;
    logic                sel_ok;
    logic                coin_present;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ovf;
    logic [CREDIT_W-1:0] remainder;

    always_comb begin
        listo_comb = '0;
        for (int i = 0; i < N_PROD; i++) begin
            listo_comb[i] = (state == CREDIT) &&
                            (credit >= price_of(i)) &&
                            !bus.sold_out[i];
        end
    end

    // Isolate the lowest set request bit (x & -x). Only that bit is ever
    // considered; an ineligible lowest bit blocks higher ones.
    assign sel_onehot = bus.comprar & (~bus.comprar + N_PROD'(1));

    always_comb begin
        sel_price = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (sel_onehot[i])
                sel_price = price_of(i);
        end
    end

    assign sel_ok       = |(sel_onehot & listo_comb);
    assign remainder    = credit - sel_price;
    assign coin_present = (bus.moneda != 2'd0);
    assign coin_sum     = add_wide(credit, coin_value(bus.moneda));
    assign coin_ovf     = coin_sum[CREDIT_W];

    // ------------------------------------------------------------------
    // Controller state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            credit       <= '0;
            vend_pulse   <= '0;
            reject_pulse <= 1'b0;
        end else begin
            vend_pulse   <= '0;
            reject_pulse <= 1'b0;

            case (state)
                CHANGE: begin
                    // One unit paid out per cycle; purchases and cancel are
                    // ignored and any inserted coin bounces.
                    if (credit != '0)
                        credit <= credit - CREDIT_W'(1);
                    if (credit <= CREDIT_W'(1))
                        state <= IDLE;
                    reject_pulse <= coin_present;
                end

                CREDIT: begin
                    if (bus.cancel) begin
                        state        <= CHANGE;
                        reject_pulse <= coin_present;
                    end else if (sel_ok) begin
                        vend_pulse   <= sel_onehot;
                        credit       <= remainder;
                        state        <= (remainder != '0) ? CHANGE : IDLE;
                        reject_pulse <= coin_present;
                    end else if (coin_present) begin
                        if (coin_ovf) begin
                            reject_pulse <= 1'b1;
                        end else begin
                            credit <= coin_sum[CREDIT_W-1:0];
                        end
                    end
                end

                IDLE: begin
                    // Cancel here has nothing to refund.
                    if (coin_present) begin
                        if (coin_ovf) begin
                            reject_pulse <= 1'b1;
                        end else begin
                            credit <= coin_sum[CREDIT_W-1:0];
                            if (coin_sum[CREDIT_W-1:0] != '0)
                                state <= CREDIT;
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    credit <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.total        = credit;
    assign bus.listo        = listo_comb;
    assign bus.vend         = vend_pulse;
    assign bus.coin_reject  = reject_pulse;
    assign bus.change_pulse = (state == CHANGE);
    assign bus.busy         = (state == CHANGE);

endmodule

// File: tb/tb_vending_fsm_n.sv
// -----------------------------------------------------------------------------
// tb_vending_fsm_n
//
// Self-checking bench for vending_fsm_n with default parameters
// (prices 2,3,4,5 for products 0..3; coin codes 1,2,3 worth 2,3,4).
// -----------------------------------------------------------------------------
module tb_vending_fsm_n;

    logic clk;
    logic reset;

    vending_fsm_n_if #(.N_PROD(4), .CREDIT_W(6)) bus ();

    vending_fsm_n #(.N_PROD(4), .CREDIT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic r, input logic [1:0] m, input logic [3:0] c,
                         input logic cn, input logic [3:0] so);
        reset        = r;
        bus.moneda   = m;
        bus.comprar  = c;
        bus.cancel   = cn;
        bus.sold_out = so;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: inputs held across one rising edge, outputs
    // checked just after that edge (inputs still applied).
    // ------------------------------------------------------------------
    typedef struct {
        logic       r;
        logic [1:0] moneda;
        logic [3:0] comprar;
        logic       cancel;
        logic [3:0] sold_out;
        logic [5:0] e_total;
        logic [3:0] e_listo;
        logic [3:0] e_vend;
        logic       e_cp;
        logic       e_rej;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    // ------------------------------------------------------------------
    // Reference model: credit held, and units still owed as change.
    // ------------------------------------------------------------------
    int         m_credit;
    int         m_refund;
    logic [3:0] m_vend;
    logic       m_rej;

    function automatic int coin_val(input logic [1:0] code);
        case (code)
            2'd1:    return 2;
            2'd2:    return 3;
            2'd3:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int price(input int i);
        return i + 2;
    endfunction

    function automatic logic [3:0] model_listo(input logic [3:0] so);
        logic [3:0] l;
        l = '0;
        for (int i = 0; i < 4; i++)
            l[i] = (m_refund == 0) && (m_credit > 0) && (m_credit >= price(i)) && !so[i];
        return l;
    endfunction

    task automatic model_step(input logic r, input logic [1:0] mon, input logic [3:0] comp,
                              input logic can, input logic [3:0] so);
        int         low;
        logic [3:0] l;
        l      = model_listo(so);
        m_vend = '0;
        m_rej  = 1'b0;
        if (r) begin
            m_credit = 0;
            m_refund = 0;
        end else if (m_refund > 0) begin
            m_refund--;
            m_rej = (mon != 0);
        end else if (m_credit > 0 && can) begin
            m_refund = m_credit;
            m_credit = 0;
            m_rej    = (mon != 0);
        end else begin
            low = -1;
            for (int i = 0; i < 4; i++)
                if (comp[i] && low < 0) low = i;
            if (low >= 0 && l[low]) begin
                m_vend   = 4'b0001 << low;
                m_refund = m_credit - price(low);
                m_credit = 0;
                m_rej    = (mon != 0);
            end else if (mon != 0) begin
                if (m_credit + coin_val(mon) > 63) m_rej = 1'b1;
                else m_credit = m_credit + coin_val(mon);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         pulses;
        int         guard;
        logic       busy_ok;
        logic [1:0] rm;
        logic [3:0] rc;
        logic       rcan;
        logic [3:0] rso;
        logic       rr;
        int         exp_total;

        //            r    mon    comp     can   so       total  listo    vend     cp    rej
        vecs[0]  = '{1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 6'd0, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000, 6'd2, 4'b0001, 4'b0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000, 6'd5, 4'b1111, 4'b0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 4'b0010, 1'b0, 4'b0000, 6'd2, 4'b0000, 4'b0010, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 6'd1, 4'b0000, 4'b0000, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 6'd0, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 2'd3, 4'b0000, 1'b0, 4'b0000, 6'd4, 4'b0111, 4'b0000, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 2'd1, 4'b1100, 1'b0, 4'b0000, 6'd0, 4'b0000, 4'b0100, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 6'd0, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000, 6'd2, 4'b0001, 4'b0000, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000, 6'd5, 4'b1111, 4'b0000, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 2'd0, 4'b1000, 1'b0, 4'b1000, 6'd5, 4'b0111, 4'b0000, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 2'd0, 4'b1001, 1'b0, 4'b1000, 6'd3, 4'b0000, 4'b0001, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 6'd2, 4'b0000, 4'b0000, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 6'd1, 4'b0000, 4'b0000, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 6'd0, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 6'd0, 4'b0000, 4'b0000, 1'b0, 1'b0};

        drive(1'b1, 2'd0, 4'b0, 1'b0, 4'b0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].r, vecs[i].moneda, vecs[i].comprar, vecs[i].cancel, vecs[i].sold_out);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_total", i), bus.total, vecs[i].e_total);
            chk($sformatf("vec%0d_listo", i), bus.listo, vecs[i].e_listo);
            chk($sformatf("vec%0d_vend", i), bus.vend, vecs[i].e_vend);
            chk($sformatf("vec%0d_change_pulse", i), bus.change_pulse, vecs[i].e_cp);
            chk($sformatf("vec%0d_busy", i), bus.busy, vecs[i].e_cp);
            chk($sformatf("vec%0d_coin_reject", i), bus.coin_reject, vecs[i].e_rej);
        end

        // Fill to 60 with fifteen 4-unit coins, then overflow attempt.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(1'b0, 2'd3, 4'b0, 1'b0, 4'b0);
            @(posedge clk);
        end
        #1;
        chk("fill_total", bus.total, 60);
        @(negedge clk);
        drive(1'b0, 2'd3, 4'b0, 1'b0, 4'b0);
        @(posedge clk);
        #1;
        chk("ovf_reject", bus.coin_reject, 1);
        chk("ovf_total", bus.total, 60);
        @(negedge clk);
        drive(1'b0, 2'd0, 4'b0, 1'b1, 4'b0);
        @(posedge clk);
        #1;
        chk("ovf_reject_clears", bus.coin_reject, 0);
        @(negedge clk);
        drive(1'b0, 2'd0, 4'b0, 1'b0, 4'b0);
        #1;
        pulses  = 0;
        guard   = 0;
        busy_ok = 1'b1;
        while (bus.change_pulse && guard < 100) begin
            pulses++;
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            guard++;
        end
        chk("refund60_pulses", pulses, 60);
        chk("refund60_busy", busy_ok, 1);
        chk("refund60_total", bus.total, 0);

        // Credit 7, cancel, coin during refund, reset after three pulses.
        @(negedge clk); drive(1'b0, 2'd1, 4'b0, 1'b0, 4'b0);
        @(negedge clk); drive(1'b0, 2'd1, 4'b0, 1'b0, 4'b0);
        @(negedge clk); drive(1'b0, 2'd2, 4'b0, 1'b0, 4'b0);
        @(posedge clk); #1;
        chk("seq6_credit", bus.total, 7);
        @(negedge clk); drive(1'b0, 2'd0, 4'b0, 1'b1, 4'b0);
        @(posedge clk); #1;
        chk("seq6_p1_cp", bus.change_pulse, 1);
        chk("seq6_p1_total", bus.total, 7);
        @(negedge clk); drive(1'b0, 2'd1, 4'b0001, 1'b0, 4'b0);
        @(posedge clk); #1;
        chk("seq6_p2_reject", bus.coin_reject, 1);
        chk("seq6_p2_total", bus.total, 6);
        chk("seq6_p2_vend", bus.vend, 0);
        @(negedge clk); drive(1'b0, 2'd0, 4'b0, 1'b0, 4'b0);
        @(posedge clk); #1;
        chk("seq6_p3_cp", bus.change_pulse, 1);
        chk("seq6_p3_total", bus.total, 5);
        @(negedge clk); drive(1'b1, 2'd0, 4'b0, 1'b0, 4'b0);
        @(posedge clk); #1;
        chk("seq6_rst_total", bus.total, 0);
        chk("seq6_rst_cp", bus.change_pulse, 0);
        chk("seq6_rst_busy", bus.busy, 0);
        chk("seq6_rst_listo", bus.listo, 0);
        @(negedge clk); drive(1'b0, 2'd0, 4'b0, 1'b0, 4'b0);
        @(posedge clk); #1;
        chk("seq6_idle_cp", bus.change_pulse, 0);

        // Randomized run against the reference model.
        @(negedge clk); drive(1'b1, 2'd0, 4'b0, 1'b0, 4'b0);
        @(posedge clk);
        m_credit = 0;
        m_refund = 0;
        m_vend   = '0;
        m_rej    = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rr   = ($urandom_range(0, 299) == 0);
            rm   = ($urandom_range(0, 9) < 4) ? 2'($urandom_range(1, 3)) : 2'd0;
            rc   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            rcan = ($urandom_range(0, 19) == 0);
            rso  = 4'($urandom & $urandom);
            drive(rr, rm, rc, rcan, rso);
            #1;
            exp_total = (m_refund > 0) ? m_refund : m_credit;
            chk("rand_total", bus.total, exp_total);
            chk("rand_listo", bus.listo, model_listo(rso));
            chk("rand_vend", bus.vend, m_vend);
            chk("rand_change_pulse", bus.change_pulse, m_refund > 0);
            chk("rand_busy", bus.busy, m_refund > 0);
            chk("rand_coin_reject", bus.coin_reject, m_rej);
            model_step(rr, rm, rc, rcan, rso);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
